tdc_core: RTL and testbench
===========================

Name: tdc_core

Overview:
- Time-to-digital converter for the ADPLL (WSN project); measures DCO cycles per reference clock period.
- Consists of a behavioural DCO and sampler front end plus a synthesizable digital decoder.
- The front end models a DCO of programmable period (fs), a 7-bit ripple counter of DCO edges and a 16-tap phase delay line, all sampled on clk.
- The digital part decodes each sample into an 11-bit position and outputs the per-clk position difference as tdc_word, unsigned Q8.4 DCO cycles.

Parameters:
- NTAPS, 16, delay-line taps; phase width.
- CNT_W, 7, ripple-counter width.
- FRAC_W, 4, fractional bits (log2 NTAPS).
- WORD_W, 12, tdc_word width.

Ports:
- clk  in  1  reference clock (32 MHz nominal), rising-edge.
- rst  in  1  asynchronous active-low reset.
- en  in  1  TDC enable, synchronous to clk.
- osc_period_fs  in  32  DCO period in femtoseconds (behavioural stimulus).
- ripple_count  out  7  sampled DCO edge count (debug).
- phase  out  16  sampled thermometer phase (debug).
- tdc_word  out  12  DCO cycles per clk period, Q8.4.

Behaviour:
- Front-end DCO model:
  - While en=1 and osc_period_fs>0, the DCO toggles with half-period osc_period_fs/2 fs.
  - A period change takes effect from the next DCO rising edge.
  - en=0 or osc_period_fs=0 stops the DCO and clears the counter and phase-tracking state to 0.
- Front-end counter:
  - ripple_count counts DCO rising edges modulo 128 and wraps 127->0.
- Front-end phase sampling, at each clk rising edge:
  - frac = floor(16*(t_now - t_last_dco_rise)/osc_period_fs), clamped to 0..15.
  - phase = thermometer code with the low frac bits set, so 0x0000 for frac=0 and 0x7FFF for frac=15.
  - ripple_count and phase are registered on the same edge and hold until the next edge.
- Front-end reset:
  - rst low clears ripple_count and phase asynchronously.
- Digital decode (combinational):
  - ones = popcount(phase) (0..15).
  - Non-thermometer (bubble) codes are decoded by popcount, not by leading-one position.
  - pos = {ripple_count, ones[3:0]} (11 bits).
- Digital registers, at clk rising edge with en=1:
  - pos_prev <= pos.
  - If primed: tdc_word <= {1'b0, (pos - pos_prev) mod 2048}.
  - primed <= 1.
  - Wrap of the counter is absorbed by the modulo-2048 subtraction; valid while the true count is below 128 cycles per clk.
- Latency:
  - Sample at edge n is decoded at edge n+1.
  - The first valid tdc_word appears at the 3rd clk edge after en rises.
- en=0:
  - tdc_word holds its last value.
  - primed <= 0, so the first difference after re-enable is discarded.
- Reset (rst low, async): tdc_word=0, pos_prev=0, primed=0.
- Reset mid-operation: restarts priming; no spurious word.
- Nominal values:
  - 400000 fs period, 31.25 ns clk -> 78.125 cycles -> tdc_word = 1250 every cycle.

Decomposition:
- Package tdc_pkg:
  - constants NTAPS, CNT_W, FRAC_W, WORD_W;
  - typedef tdc_pos_t (logic [10:0]);
  - function popcount16.
- Sub-module tdc_frontend_model: behavioural DCO, counter and phase sampler; uses realtime, not synthesizable.
- tdc_core instantiates tdc_frontend_model and contains the synthesizable decode and registers.

Test Plan:
- Reset: rst low with clk running -> tdc_word=0, ripple_count=0, phase=0; rst high with en=0 -> tdc_word stays 0.
- Nominal: osc_period_fs=400000, en=1 -> tdc_word=0 for 2 edges, then 1250 (0x4E2) on every edge.
- Fine step: osc_period_fs=400023 -> tdc_word in {1249,1250}, mean over 200 edges 1249.93 +/-0.05.
- Wrap: observe ripple_count crossing 127->0 -> tdc_word unaffected (still 1250 at 400000 fs).
- Disable/re-enable: en 1->0 -> tdc_word holds 1250; en 0->1 -> word held for 2 edges, then 1250 again.
- Async reset mid-run: rst pulsed low between clk edges -> tdc_word=0 immediately; after release, 2 edges of 0, then 1250.

Source files
------------

// File: rtl/tdc_pkg.sv
`timescale 1ns/1fs
// Shared constants, types and helpers for the ADPLL time-to-digital converter.
// Position is {ripple count, fine phase}; one LSB is 1/16 of a DCO period.
package tdc_pkg;

    localparam int NTAPS  = 16;
    localparam int CNT_W  = 7;
    localparam int FRAC_W = 4;
    localparam int WORD_W = 12;
    localparam int POS_W  = CNT_W + FRAC_W;

    typedef logic [POS_W-1:0] tdc_pos_t;

    // Popcount rather than leading-one search so bubbles cost at most one LSB.
    // A legal thermometer never has all 16 taps set, so 4 bits are enough.
    function automatic logic [FRAC_W-1:0] popcount16(input logic [NTAPS-1:0] v);
        logic [FRAC_W-1:0] n;
        n = '0;
        for (int i = 0; i < NTAPS; i++) begin
            n = n + FRAC_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/tdc_frontend_model.sv
`timescale 1ns/1fs
// Behavioural DCO, 7-bit edge counter and 16-tap delay-line sampler (simulation only).
// Latency: ripple_count/phase registered on each clk rising edge, held until the next.
// Backpressure: none; en=0, zero period or rst low stops the DCO and clears the sample.
module tdc_frontend_model
    import tdc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      osc_period_fs,
    output logic [CNT_W-1:0] ripple_count,
    output logic [NTAPS-1:0] phase
);

    localparam real FS_PER_NS = 1.0e6;

    logic run_q;
    real  t_last_q;
    real  per_q;
    real  p_fs;

    always_comb p_fs = real'(osc_period_fs);

    function automatic real now_fs();
        return $realtime * FS_PER_NS;
    endfunction

    // The next rise still uses the old period; later rises use the new one.
    function automatic longint rises(input real t_last, input real per,
                                     input real t_now, input real p);
        if (t_now < t_last + per) return 0;
        return 1 + longint'($floor((t_now - t_last - per) / p));
    endfunction

    function automatic real last_rise(input real t_last, input real per,
                                      input real t_now, input real p);
        longint n;
        n = rises(t_last, per, t_now, p);
        if (n == 0) return t_last;
        return t_last + per + real'(n - 1) * p;
    endfunction

    function automatic logic [NTAPS-1:0] therm_of(input real dt, input real p);
        real f;
        int  k;
        f = $floor(real'(NTAPS) * dt / p);
        if (f < 0.0)                     k = 0;
        else if (f > real'(NTAPS - 1))   k = NTAPS - 1;
        else                             k = int'(f);
        return (NTAPS'(1) << k) - NTAPS'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q        <= 1'b0;
            t_last_q     <= 0.0;
            per_q        <= 0.0;
            ripple_count <= '0;
            phase        <= '0;
        end else if (!en || osc_period_fs == '0) begin
            run_q        <= 1'b0;
            t_last_q     <= 0.0;
            per_q        <= 0.0;
            ripple_count <= '0;
            phase        <= '0;
        end else if (!run_q) begin
            run_q        <= 1'b1;
            t_last_q     <= now_fs();
            per_q        <= p_fs;
            ripple_count <= '0;
            phase        <= '0;
        end else begin
            t_last_q     <= last_rise(t_last_q, per_q, now_fs(), p_fs);
            per_q        <= (rises(t_last_q, per_q, now_fs(), p_fs) > 0) ? p_fs : per_q;
            ripple_count <= ripple_count + CNT_W'(rises(t_last_q, per_q, now_fs(), p_fs));
            phase        <= therm_of(now_fs() - last_rise(t_last_q, per_q, now_fs(), p_fs), p_fs);
        end
    end

endmodule

// File: rtl/tdc_core.sv
`timescale 1ns/1fs
// TDC: decodes each front-end sample to a position and outputs per-clk deltas (Q8.4).
// Latency: sample at edge n decoded at edge n+1; first valid word on 3rd edge after en.
// Backpressure: none; en=0 holds tdc_word and re-primes the difference pipeline.
module tdc_core
    import tdc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [31:0]       osc_period_fs,
    output logic [CNT_W-1:0]  ripple_count,
    output logic [NTAPS-1:0]  phase,
    output logic [WORD_W-1:0] tdc_word
);

    tdc_frontend_model u_fe (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .osc_period_fs(osc_period_fs),
        .ripple_count (ripple_count),
        .phase        (phase)
    );

    tdc_pos_t          pos;
    tdc_pos_t          pos_prev_q, pos_prev_d;
    logic [1:0]        prime_q, prime_d;
    logic [WORD_W-1:0] tdc_word_q, tdc_word_d;

    always_comb pos = {ripple_count, popcount16(phase)};

    // Two enabled edges are needed: the first difference spans the DCO start.
    always_comb begin
        pos_prev_d = pos_prev_q;
        prime_d    = prime_q;
        tdc_word_d = tdc_word_q;
        if (en) begin
            pos_prev_d = pos;
            prime_d    = {prime_q[0], 1'b1};
            if (prime_q[1]) begin
                tdc_word_d = {1'b0, tdc_pos_t'(pos - pos_prev_q)};
            end
        end else begin
            prime_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos_prev_q <= '0;
            prime_q    <= '0;
            tdc_word_q <= '0;
        end else begin
            pos_prev_q <= pos_prev_d;
            prime_q    <= prime_d;
            tdc_word_q <= tdc_word_d;
        end
    end

    assign tdc_word = tdc_word_q;

endmodule

// File: tb/tb_tdc_core.sv
`timescale 1ns/1fs
// Directed bench for tdc_core: reset, nominal, wrap, disable, async reset, fine step.
module tb_tdc_core;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en  = 1'b0;
    logic [31:0] osc_period_fs = 32'd400000;
    logic [6:0]  ripple_count;
    logic [15:0] phase;
    logic [11:0] tdc_word;

    int checks = 0;
    int errors = 0;

    tdc_core dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .osc_period_fs(osc_period_fs),
        .ripple_count (ripple_count),
        .phase        (phase),
        .tdc_word     (tdc_word)
    );

    always #15.625 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        en  = 1'b0;
        repeat (3) step();
        checks++; if (tdc_word !== 12'd0) begin errors++; $display("FAIL reset_word got=%0d exp=0", tdc_word); end
        checks++; if (ripple_count !== 7'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", ripple_count); end
        checks++; if (phase !== 16'h0000) begin errors++; $display("FAIL reset_phase got=%h exp=0000", phase); end
        rst = 1'b1;
        repeat (3) step();
        checks++; if (tdc_word !== 12'd0) begin errors++; $display("FAIL reset_idle_word got=%0d exp=0", tdc_word); end
    endtask

    task automatic test_nominal();
        logic [11:0] exp;
        osc_period_fs = 32'd400000;
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step();
            exp = (k <= 2) ? 12'd0 : 12'd1250;
            checks++;
            if (tdc_word !== exp) begin
                errors++; $display("FAIL nominal edge=%0d got=%0d exp=%0d", k, tdc_word, exp);
            end
        end
    endtask

    task automatic test_wrap();
        logic [6:0] prev;
        bit         wrapped;
        wrapped = 1'b0;
        prev = ripple_count;
        for (int k = 0; k < 20; k++) begin
            step();
            if (ripple_count < prev) wrapped = 1'b1;
            prev = ripple_count;
            checks++;
            if (tdc_word !== 12'd1250) begin
                errors++; $display("FAIL wrap_word edge=%0d got=%0d exp=1250", k, tdc_word);
            end
        end
        checks++;
        if (wrapped !== 1'b1) begin errors++; $display("FAIL wrap_seen got=%0d exp=1", wrapped); end
    endtask

    task automatic test_disable();
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (tdc_word !== 12'd1250) begin errors++; $display("FAIL disable_hold edge=%0d got=%0d exp=1250", k, tdc_word); end
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            checks++;
            if (tdc_word !== 12'd1250) begin errors++; $display("FAIL reenable edge=%0d got=%0d exp=1250", k, tdc_word); end
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] exp;
        @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        checks++; if (tdc_word !== 12'd0) begin errors++; $display("FAIL arst_word got=%0d exp=0", tdc_word); end
        checks++; if (ripple_count !== 7'd0) begin errors++; $display("FAIL arst_count got=%0d exp=0", ripple_count); end
        #4;
        rst = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            step();
            exp = (k <= 2) ? 12'd0 : 12'd1250;
            checks++;
            if (tdc_word !== exp) begin errors++; $display("FAIL arst_recover edge=%0d got=%0d exp=%0d", k, tdc_word, exp); end
        end
    endtask

    task automatic test_fine_step();
        int sum;
        en = 1'b0;
        step();
        osc_period_fs = 32'd400023;
        en = 1'b1;
        repeat (2) step();
        sum = 0;
        for (int k = 0; k < 200; k++) begin
            step();
            sum += int'(tdc_word);
            checks++;
            if (tdc_word !== 12'd1249 && tdc_word !== 12'd1250) begin
                errors++; $display("FAIL fine_word edge=%0d got=%0d exp=1249..1250", k, tdc_word);
            end
        end
        // mean 1249.93 +/- 0.05 over 200 words
        checks++;
        if (sum < 249976 || sum > 249996) begin
            errors++; $display("FAIL fine_mean sum=%0d exp=249976..249996", sum);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_wrap();
        test_disable();
        test_async_reset();
        test_fine_step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
